// File: rtl/acc_pkg.sv
// Shared defaults and state encoding for the 40-bit framed accumulator.
package acc_pkg;
  localparam int ACC_WIDTH = 40;
  localparam int ACC_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } acc_state_e;
endpackage

// File: rtl/rca_40b.sv
// 40-bit ripple-carry adder: a chain of full-adder cells, purely combinational.
module rca_40b #(
  parameter int WIDTH = 40
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  logic [WIDTH:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[WIDTH];
endmodule

// File: rtl/acc_40b.sv
// Framed multi-operand accumulator around rca_40b with sticky carry/overflow,
// saturating operand count and a valid/ready result handshake.
module acc_40b
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int CNT_W = ACC_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);
  acc_state_e       state_q;
  logic [WIDTH-1:0] acc_q;
  logic             cout_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             xfer;

  rca_40b #(.WIDTH(WIDTH)) rca_U0 (
    .a_i   (acc_q),
    .b_i   (in_data),
    .cin_i (1'b0),
    .sum_o (sum_d),
    .cout_o(cout_d)
  );

  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf_d = (acc_q[WIDTH-1] == in_data[WIDTH-1]) && (sum_d[WIDTH-1] != acc_q[WIDTH-1]);
  assign xfer  = in_valid && (state_q == ST_ACCUM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (xfer) begin
            acc_q  <= sum_d;
            cout_q <= cout_q | cout_d;
            ovf_q  <= ovf_q | ovf_d;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            if (in_last) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_sum   = acc_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;
endmodule

// File: tb/tb_acc_40b.sv
// Directed bench for acc_40b: a reference model pushes expected frame results
// into a scoreboard queue and each DUT result is popped and compared.
module tb_acc_40b;
  localparam int W  = 40;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic [CW-1:0] out_count;
  logic          busy;

  acc_40b #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic [CW-1:0] cnt;
  } res_t;

  res_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0]  m_sum;
  logic          m_cout;
  logic          m_ovf;
  logic [CW-1:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_cnt = '0;
  endtask

  task automatic model_add(input logic [W-1:0] d);
    logic [W:0] u;
    logic signed [W:0] s;
    u = {1'b0, m_sum} + {1'b0, d};
    s = $signed({m_sum[W-1], m_sum}) + $signed({d[W-1], d});
    if (u[W]) m_cout = 1'b1;
    if (s[W] != s[W-1]) m_ovf = 1'b1;
    m_sum = u[W-1:0];
    if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
    chk("start_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  // Offers one operand after 'gaps' idle cycles; the model only advances on a transfer.
  task automatic send(input logic [W-1:0] d, input logic last, input int gaps);
    int w;
    res_t r;
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom} ;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 20) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    model_add(d);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (last) begin
      r.sum = m_sum; r.cout = m_cout; r.ovf = m_ovf; r.cnt = m_cnt;
      sb.push_back(r);
    end
  endtask

  // Called right after the last-operand edge; result must already be valid.
  task automatic collect(input string tag, input int hold);
    res_t r;
    int w;
    chk({tag, "_latency1"}, {63'd0, out_valid}, 64'd1);
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    r = sb.pop_front();
    chk({tag, "_sum"},   {24'd0, out_sum},   {24'd0, r.sum});
    chk({tag, "_cout"},  {63'd0, out_cout},  {63'd0, r.cout});
    chk({tag, "_ovf"},   {63'd0, out_ovf},   {63'd0, r.ovf});
    chk({tag, "_count"}, {60'd0, out_count}, {60'd0, r.cnt});
    // Backpressure: start and stray operands must be ignored while DONE waits.
    for (int h = 0; h < hold; h++) begin
      start = 1'b1; in_valid = 1'b1; in_data = {$urandom, $urandom}; in_last = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_hold_ready"}, {63'd0, in_ready}, 64'd0);
      chk({tag, "_hold_sum"},   {24'd0, out_sum}, {24'd0, r.sum});
      chk({tag, "_hold_count"}, {60'd0, out_count}, {60'd0, r.cnt});
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_idle"},       {63'd0, busy}, 64'd0);
    chk({tag, "_keep_sum"},   {24'd0, out_sum}, {24'd0, r.sum});
  endtask

  initial begin
    #1;
    chk("rst_sum",   {24'd0, out_sum}, 64'd0);
    chk("rst_flags", {60'd0, out_valid, in_ready, out_cout, out_ovf}, 64'd0);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // in_valid in IDLE is ignored
    in_valid = 1'b1; in_data = 40'd77; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("idle_ignore_busy", {63'd0, busy}, 64'd0);
    chk("idle_ignore_sum",  {24'd0, out_sum}, 64'd0);

    // asynchronous reset mid-frame
    start_frame();
    send(40'd9, 1'b0, 0);
    send(40'd11, 1'b0, 0);
    chk("pre_rst_sum", {24'd0, out_sum}, 64'd20);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_sum",   {24'd0, out_sum}, 64'd0);
    chk("async_rst_count", {60'd0, out_count}, 64'd0);
    chk("async_rst_busy",  {61'd0, busy, in_ready, out_valid}, 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    start_frame();
    send(40'd5, 1'b1, 0);
    collect("post_rst", 0);

    // basic frame
    start_frame();
    send(40'd3, 1'b0, 0);
    send(40'd4, 1'b0, 0);
    send(40'h00000000FF, 1'b1, 0);
    chk("basic_sum_const", {24'd0, out_sum}, 64'h106);
    collect("basic", 0);

    // unsigned carry
    start_frame();
    send(40'hFFFFFFFFFF, 1'b0, 0);
    send(40'h0000000001, 1'b1, 0);
    chk("carry_const", {22'd0, out_sum, out_cout, out_ovf}, {22'd0, 40'd0, 1'b1, 1'b0});
    collect("carry", 0);

    // signed overflow, positive direction
    start_frame();
    send(40'h7FFFFFFFFF, 1'b0, 0);
    send(40'h0000000001, 1'b1, 0);
    chk("ovf_const", {22'd0, out_sum, out_cout, out_ovf}, {22'd0, 40'h8000000000, 1'b0, 1'b1});
    collect("ovf_pos", 0);

    // signed overflow, negative direction with carry
    start_frame();
    send(40'h8000000000, 1'b0, 0);
    send(40'h8000000000, 1'b1, 0);
    chk("ovf_neg_const", {22'd0, out_sum, out_cout, out_ovf}, {22'd0, 40'd0, 1'b1, 1'b1});
    collect("ovf_neg", 0);

    // random in_valid gaps, then 5-cycle backpressure in DONE
    start_frame();
    for (int i = 0; i < 6; i++)
      send({$urandom, $urandom}, (i == 5), $urandom_range(0, 3));
    collect("gaps_bp", 5);

    // counter saturation at 15
    start_frame();
    for (int i = 0; i < 20; i++) send(40'd1, (i == 19), 0);
    chk("sat_const", {20'd0, out_sum, out_count}, {20'd0, 40'd20, 4'd15});
    collect("sat", 0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/acc_40b.md
Name: acc_40b

Overview:
- Sequential accumulator that sits directly downstream of the existing 40-bit ripple-carry adder (rca_40b) and instantiates it as its datapath.
- Sums a framed stream of 40-bit operands into a running total and tracks carry-out and signed overflow.
- Counts the operands it accepts and presents the final total through a valid/ready result handshake.
- Used wherever a multi-operand sum is needed from the single-cycle adder.

Parameters:
- WIDTH, 40, datapath width; must match rca_40b.
- CNT_W, 8, operand-counter width.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  begin a new frame; honoured only in IDLE
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  accumulator accepts an operand this cycle
- in_data  input  WIDTH  operand
- in_last  input  1  marks final operand of frame
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_sum  output  WIDTH  accumulated total (mod 2^WIDTH)
- out_cout  output  1  sticky unsigned carry-out seen during frame
- out_ovf  output  1  sticky two's-complement overflow seen during frame
- out_count  output  CNT_W  operands accepted in frame (saturating)
- busy  output  1  state != IDLE

Behaviour:
- Clock, reset and state encoding:
  - Single clock domain.
  - reset_n=0 asynchronously forces state=IDLE, acc=0, cout_s=0, ovf_s=0, cnt=0.
  - All outputs are therefore 0 during and after reset.
  - A reset mid-frame discards the partial sum; no result is emitted.
  - States: IDLE (00), ACCUM (01), DONE (10).
  - Encoding 11 is illegal and returns to IDLE on the next clock.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 → next cycle acc=0, cnt=0, cout_s=0, ovf_s=0, state=ACCUM.
  - in_valid is ignored in IDLE.
- ACCUM:
  - in_ready=1; start is ignored.
  - Transfer occurs when in_valid & in_ready.
  - On a transfer at edge k:
    - acc <= S of rca_40b(A=acc, B=in_data, Cin=0).
    - cout_s <= cout_s | Cout.
    - ovf_s <= ovf_s | (acc[W-1]==in_data[W-1] && S[W-1]!=acc[W-1]).
    - cnt <= cnt+1, holding at 2^CNT_W-1 once reached (no wrap).
  - Transfer with in_last=1 → state=DONE at edge k; the result is visible in cycle k+1 (latency 1 from the last operand).
  - No transfer → all registers hold.
- DONE:
  - out_valid=1; in_ready=0.
  - out_sum, out_cout, out_ovf and out_count hold stable until out_valid & out_ready.
  - Handshake → state=IDLE next cycle; out_valid drops.
  - out_sum and flags keep their last values in IDLE until the next start clears them.
  - start asserted while in DONE is ignored. A new frame needs start in IDLE, so at least one IDLE cycle separates frames.
- Adder path and outputs:
  - Adder path is combinational, acc→rca_40b→acc, single cycle; no pipelining.
  - Cin is tied to 0.
  - out_sum = acc, out_cout = cout_s, out_ovf = ovf_s, out_count = cnt, all driven straight from registers.
  - in_ready and out_valid are decoded from state only; no combinational path from inputs.
- Zero-length frame: impossible. A frame ends only on an accepted in_last, so a frame has at least one operand.

Decomposition:
- Shared package acc_pkg: WIDTH default, state encodings IDLE/ACCUM/DONE, CNT_W default.
- Sub-module: the existing rca_40b (instance rca_U0), unmodified. No other sub-modules.
- The overflow detect and saturating counter stay inline.

Test Plan:
- Reset: hold reset_n=0 mid-ACCUM after two operands → all outputs 0, state IDLE immediately (asynchronous). Release, start, send 5 with last → out_sum=5, out_count=1.
- Basic frame: start; send 3, 4, 40'h00000000FF (last) → out_valid one cycle after last; out_sum=40'h0000000106, out_count=3, out_cout=0, out_ovf=0.
- Unsigned carry: send 40'hFFFFFFFFFF, then 40'h0000000001 (last) → out_sum=0, out_cout=1, out_ovf=0.
- Signed overflow: send 40'h7FFFFFFFFF, then 40'h0000000001 (last) → out_sum=40'h8000000000, out_ovf=1, out_cout=0. Also send 40'h8000000000 twice → sum=0, cout=1, ovf=1.
- Handshake/backpressure:
  - Toggle in_valid randomly during the frame → only accepted beats counted.
  - Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, and start plus extra in_valid are ignored.
  - Then assert out_ready → IDLE next cycle.
- Counter saturation: CNT_W=4, send 20 operands of value 1 → out_count=15, out_sum=20.
